game_over_banner: RTL and testbench

Animated, parametrised "GAME OVER" overlay renderer for the VGA pixel pipeline. The block keeps a glyph ROM and tracks banner position and visibility in a frame-synchronous state machine: slide-in, blink, then hold. It returns a registered 1-bit-per-channel pixel for the current CounterX/CounterY. It sits beside the playfield renderer and is OR-ed into the final RGB mux.

---
 rtl/game_over_banner.sv | 180 ++++++++++++++++++
 tb/tb_game_over_banner.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_over_banner.sv
// "GAME OVER" overlay renderer: slides in, blinks, then holds; registered 1-bit-per-channel pixel.
// Optional slide-in phase is enabled by defining BANNER_SLIDE_EN (otherwise trigger goes straight to blink).
module game_over_banner #(
   parameter int         CELL_SHIFT    = 3,
   parameter int         ORG_X         = 192,
   parameter int         ORG_Y         = 180,
   parameter int         SLIDE_START   = 300,
   parameter int         SLIDE_STEP    = 20,
   parameter int         BLINK_FRAMES  = 15,
   parameter int         BLINK_TOGGLES = 6,
   parameter logic [2:0] FG_RGB        = 3'b111
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] CounterX,
   input  logic [8:0] CounterY,
   input  logic       frame_tick,
   input  logic       trigger,
   input  logic       ack,
   output logic       vga_R,
   output logic       vga_G,
   output logic       vga_B,
   output logic       active,
   output logic       done
);
   localparam int FW = $clog2(BLINK_FRAMES + 1);
   localparam int TW = $clog2(BLINK_TOGGLES + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SLIDE, ST_BLINK, ST_HOLD} state_t;

   // Glyphs G A M E O V R (+ blank); row 7 is zero padding, bit 6 is the leftmost cell.
   localparam logic [7:0] GLYPH_ROM [0:7][0:7] = '{
      '{8'h3E, 8'h63, 8'h60, 8'h67, 8'h63, 8'h63, 8'h3E, 8'h00},
      '{8'h1C, 8'h36, 8'h63, 8'h63, 8'h7F, 8'h63, 8'h63, 8'h00},
      '{8'h41, 8'h63, 8'h77, 8'h7F, 8'h6B, 8'h63, 8'h63, 8'h00},
      '{8'h7F, 8'h60, 8'h60, 8'h7E, 8'h60, 8'h60, 8'h7F, 8'h00},
      '{8'h3E, 8'h63, 8'h63, 8'h63, 8'h63, 8'h63, 8'h3E, 8'h00},
      '{8'h63, 8'h63, 8'h63, 8'h63, 8'h63, 8'h36, 8'h1C, 8'h00},
      '{8'h7E, 8'h63, 8'h63, 8'h7E, 8'h6C, 8'h66, 8'h63, 8'h00},
      '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}
   };

   state_t          r_state, w_state_nx;
   logic            r_vis, w_vis_nx;
   logic [FW-1:0]   r_frame, w_frame_nx;
   logic [TW-1:0]   r_tog, w_tog_nx;
   logic [2:0]      r_pix;
   logic [9:0]      w_yoff;

`ifdef BANNER_SLIDE_EN
   logic [9:0]      r_yoff, w_yoff_nx;

   always_ff @(posedge clk) begin
      if (rst) r_yoff <= 10'(SLIDE_START);
      else     r_yoff <= w_yoff_nx;
   end
   assign w_yoff = r_yoff;
`else
   logic            w_unused_slide;
   assign w_unused_slide = (SLIDE_START != SLIDE_STEP);
   assign w_yoff         = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_vis   <= 1'b0;
         r_frame <= '0;
         r_tog   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_vis   <= w_vis_nx;
         r_frame <= w_frame_nx;
         r_tog   <= w_tog_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_vis_nx   = r_vis;
      w_frame_nx = r_frame;
      w_tog_nx   = r_tog;
`ifdef BANNER_SLIDE_EN
      w_yoff_nx  = r_yoff;
`endif
      if (ack && (r_state != ST_IDLE)) begin
         w_state_nx = ST_IDLE;
         w_vis_nx   = 1'b0;
         w_frame_nx = '0;
         w_tog_nx   = '0;
`ifdef BANNER_SLIDE_EN
         w_yoff_nx  = 10'(SLIDE_START);
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (trigger) begin
`ifdef BANNER_SLIDE_EN
                  w_state_nx = ST_SLIDE;
`else
                  w_state_nx = ST_BLINK;
`endif
                  w_vis_nx   = 1'b1;
                  w_frame_nx = '0;
                  w_tog_nx   = '0;
               end
            end
`ifdef BANNER_SLIDE_EN
            ST_SLIDE: begin
               if (frame_tick) begin
                  if (r_yoff > 10'(SLIDE_STEP)) begin
                     w_yoff_nx = r_yoff - 10'(SLIDE_STEP);
                  end else begin
                     w_yoff_nx  = '0;
                     w_state_nx = ST_BLINK;
                  end
               end
            end
`endif
            ST_BLINK: begin
               if (frame_tick) begin
                  if (r_frame == FW'(BLINK_FRAMES - 1)) begin
                     w_frame_nx = '0;
                     w_tog_nx   = r_tog + TW'(1);
                     if (w_tog_nx == TW'(BLINK_TOGGLES)) begin
                        w_state_nx = ST_HOLD;
                        w_vis_nx   = 1'b1;
                     end else begin
                        w_vis_nx   = ~r_vis;
                     end
                  end else begin
                     w_frame_nx = r_frame + FW'(1);
                  end
               end
            end
            ST_HOLD: w_vis_nx = 1'b1;
            default: w_state_nx = ST_IDLE;
         endcase
      end
   end

   // Negative offsets are caught by the sign bit before the cell indices are used.
   logic [10:0] w_dx, w_dy, w_col, w_row;
   logic [2:0]  w_ch;
   logic [7:0]  w_glyph_row;
   logic        w_hit, w_pix_on;

   assign w_dx = {1'b0, CounterX} - 11'(ORG_X);
   assign w_dy = {2'b00, CounterY} - 11'(ORG_Y) - {1'b0, w_yoff};
   assign w_col = w_dx >> CELL_SHIFT;
   assign w_row = w_dy >> CELL_SHIFT;

   always_comb begin
      case ({w_row[3], w_col[4:3]})
         3'd0:    w_ch = 3'd0;
         3'd1:    w_ch = 3'd1;
         3'd2:    w_ch = 3'd2;
         3'd3:    w_ch = 3'd3;
         3'd4:    w_ch = 3'd4;
         3'd5:    w_ch = 3'd5;
         3'd6:    w_ch = 3'd3;
         default: w_ch = 3'd6;
      endcase
   end

   assign w_glyph_row = GLYPH_ROM[w_ch][w_row[2:0]];
   assign w_hit = !w_dx[10] && !w_dy[10] && (w_col < 11'd31) && (w_row < 11'd15)
                  && (w_col[2:0] != 3'd7) && (w_row[2:0] != 3'd7)
                  && w_glyph_row[3'd6 - w_col[2:0]];
   assign w_pix_on = w_hit && r_vis && (r_state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) r_pix <= '0;
      else     r_pix <= w_pix_on ? FG_RGB : 3'b000;
   end

   assign {vga_R, vga_G, vga_B} = r_pix;
   assign active = (r_state != ST_IDLE);
   assign done   = (r_state == ST_HOLD);
endmodule

// File: tb/tb_game_over_banner.sv
// Bench for game_over_banner: directed boundary checks plus randomized stimulus against a tick-count model.
module tb_game_over_banner;
   localparam int         CELL_SHIFT    = 3;
   localparam int         ORG_X         = 192;
   localparam int         ORG_Y         = 180;
   localparam int         SLIDE_START   = 300;
   localparam int         SLIDE_STEP    = 20;
   localparam int         BLINK_FRAMES  = 15;
   localparam int         BLINK_TOGGLES = 6;
   localparam logic [2:0] FG_RGB        = 3'b111;
`ifdef BANNER_SLIDE_EN
   localparam int NS = (SLIDE_START + SLIDE_STEP - 1) / SLIDE_STEP;
`else
   localparam int NS = 0;
`endif
   localparam int NB = BLINK_FRAMES * BLINK_TOGGLES;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] CounterX = '0;
   logic [8:0] CounterY = '0;
   logic       frame_tick = 1'b0;
   logic       trigger = 1'b0;
   logic       ack = 1'b0;
   logic       vga_R, vga_G, vga_B, active, done;

   game_over_banner #(
      .CELL_SHIFT(CELL_SHIFT), .ORG_X(ORG_X), .ORG_Y(ORG_Y),
      .SLIDE_START(SLIDE_START), .SLIDE_STEP(SLIDE_STEP),
      .BLINK_FRAMES(BLINK_FRAMES), .BLINK_TOGGLES(BLINK_TOGGLES), .FG_RGB(FG_RGB)
   ) dut (
      .clk(clk), .rst(rst), .CounterX(CounterX), .CounterY(CounterY),
      .frame_tick(frame_tick), .trigger(trigger), .ack(ack),
      .vga_R(vga_R), .vga_G(vga_G), .vga_B(vga_B), .active(active), .done(done)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_errors = 0;
   bit   m_armed = 1'b0;
   int   m_n = 0;
   logic [2:0] exp_rgb = '0;
   logic exp_active = 1'b0;
   logic exp_done = 1'b0;
   bit   exp_valid = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endtask

   // Model: the whole animation is a function of frame ticks counted since the trigger.
   function automatic int m_yoff();
      if (m_n >= NS) return 0;
      return SLIDE_START - m_n * SLIDE_STEP;
   endfunction

   function automatic bit m_vis();
      int b;
      if (m_n < NS) return 1'b1;
      b = m_n - NS;
      if (b >= NB) return 1'b1;
      return ((b / BLINK_FRAMES) % 2) == 0;
   endfunction

   function automatic bit m_done();
      return m_armed && (m_n >= NS + NB);
   endfunction

   function automatic logic [55:0] glyph(input byte c);
      case (c)
         "G":     return 56'h3E_63_60_67_63_63_3E;
         "A":     return 56'h1C_36_63_63_7F_63_63;
         "M":     return 56'h41_63_77_7F_6B_63_63;
         "E":     return 56'h7F_60_60_7E_60_60_7F;
         "O":     return 56'h3E_63_63_63_63_63_3E;
         "V":     return 56'h63_63_63_63_63_36_1C;
         "R":     return 56'h7E_63_63_7E_6C_66_63;
         default: return 56'h0;
      endcase
   endfunction

   function automatic logic [2:0] model_pix(input int x, input int y);
      int cs, dx, dy, col, row;
      logic [55:0] g;
      logic [7:0]  rb;
      string banner;
      banner = "GAMEOVER";
      if (!m_armed || !m_vis()) return 3'b000;
      cs = 1 << CELL_SHIFT;
      dx = x - ORG_X;
      dy = y - (ORG_Y + m_yoff());
      if (dx < 0 || dy < 0) return 3'b000;
      col = dx / cs;
      row = dy / cs;
      if (col >= 31 || row >= 15 || (col % 8) == 7 || (row % 8) == 7) return 3'b000;
      g  = glyph(banner[(row / 8) * 4 + col / 8]);
      rb = g[(6 - row % 8) * 8 +: 8];
      return rb[6 - col % 8] ? FG_RGB : 3'b000;
   endfunction

   task automatic model_step(input logic r, input logic tk, input logic tr, input logic ak);
      if (r) begin
         m_armed = 1'b0;
         m_n     = 0;
      end else if (ak && m_armed) begin
         m_armed = 1'b0;
      end else if (!m_armed) begin
         if (tr) begin
            m_armed = 1'b1;
            m_n     = 0;
         end
      end else if (tk && m_n < NS + NB) begin
         m_n++;
      end
   endtask

   task automatic cyc(input int x, input int y, input logic tk, input logic tr,
                      input logic ak, input logic r);
      @(negedge clk);
      CounterX   = 10'(x);
      CounterY   = 9'(y);
      frame_tick = tk;
      trigger    = tr;
      ack        = ak;
      rst        = r;
      exp_rgb    = r ? 3'b000 : model_pix(x, y);
      model_step(r, tk, tr, ak);
      exp_active = m_armed;
      exp_done   = m_done();
      exp_valid  = 1'b1;
   endtask

   task automatic lit(input string name, input logic [2:0] rgb, input logic act, input logic dn);
      @(posedge clk);
      #2;
      check({name, " rgb"}, 32'({vga_R, vga_G, vga_B}), 32'(rgb));
      check({name, " active"}, 32'(active), 32'(act));
      check({name, " done"}, 32'(done), 32'(dn));
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_valid) begin
         check("model rgb", 32'({vga_R, vga_G, vga_B}), 32'(exp_rgb));
         check("model active", 32'(active), 32'(exp_active));
         check("model done", 32'(done), 32'(exp_done));
         exp_valid = 1'b0;
      end
   end

   initial begin
      repeat (3) cyc(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      lit("reset", 3'b000, 1'b0, 1'b0);

      for (int i = 0; i < 400; i++)
         cyc(int'($urandom_range(1023, 0)), int'($urandom_range(511, 0)),
             1'($urandom_range(1, 0)), 1'b0, 1'($urandom_range(1, 0)), 1'b0);

      cyc(200, 180, 1'b0, 1'b1, 1'b0, 1'b0);
      lit("trigger", 3'b000, 1'b1, 1'b0);
`ifdef BANNER_SLIDE_EN
      cyc(200, 180, 1'b0, 1'b0, 1'b0, 1'b0);
      lit("slide start low", 3'b000, 1'b1, 1'b0);
`endif
      repeat (NS) cyc(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(200, 180, 1'b0, 1'b0, 1'b0, 1'b0);
      lit("blink entry G r0c1", FG_RGB, 1'b1, 1'b0);
      repeat (14) cyc(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(200, 180, 1'b0, 1'b0, 1'b0, 1'b0);
      lit("blink tick14 visible", FG_RGB, 1'b1, 1'b0);
      cyc(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(200, 180, 1'b0, 1'b0, 1'b0, 1'b0);
      lit("blink tick15 hidden", 3'b000, 1'b1, 1'b0);
      repeat (14) cyc(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(200, 180, 1'b0, 1'b0, 1'b0, 1'b0);
      lit("blink tick29 hidden", 3'b000, 1'b1, 1'b0);
      cyc(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(200, 180, 1'b0, 1'b0, 1'b0, 1'b0);
      lit("blink tick30 visible", FG_RGB, 1'b1, 1'b0);
      repeat (59) cyc(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      lit("blink tick89", 3'b000, 1'b1, 1'b0);
      cyc(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      lit("hold after tick90", 3'b000, 1'b1, 1'b1);

      cyc(192, 180, 1'b0, 1'b0, 1'b0, 1'b0);
      lit("hold 192,180", 3'b000, 1'b1, 1'b1);
      cyc(200, 180, 1'b0, 1'b0, 1'b0, 1'b0);
      lit("hold 200,180", FG_RGB, 1'b1, 1'b1);
      cyc(248, 180, 1'b0, 1'b0, 1'b0, 1'b0);
      lit("hold gap 248,180", 3'b000, 1'b1, 1'b1);
      cyc(256, 244, 1'b0, 1'b0, 1'b0, 1'b0);
      lit("hold 256,244", FG_RGB, 1'b1, 1'b1);
      cyc(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      lit("hold trigger ignored", 3'b000, 1'b1, 1'b1);

      cyc(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
      lit("ack beats trigger", 3'b000, 1'b0, 1'b0);
      cyc(200, 180, 1'b0, 1'b1, 1'b0, 1'b0);
      lit("held trigger rearms", 3'b000, 1'b1, 1'b0);
      repeat (NS + 5) cyc(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(200, 180, 1'b1, 1'b1, 1'b1, 1'b0);
      lit("ack+tick in blink", FG_RGB, 1'b0, 1'b0);
      cyc(200, 180, 1'b0, 1'b0, 1'b0, 1'b0);
      lit("after ack dark", 3'b000, 1'b0, 1'b0);
      cyc(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
      lit("ack idle ignored", 3'b000, 1'b0, 1'b0);

      cyc(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (3) cyc(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(200, 180, 1'b0, 1'b0, 1'b0, 1'b1);
      lit("reset mid animation", 3'b000, 1'b0, 1'b0);
      cyc(200, 180, 1'b0, 1'b1, 1'b0, 1'b0);
      lit("retrigger", 3'b000, 1'b1, 1'b0);
`ifdef BANNER_SLIDE_EN
      cyc(200, 420, 1'b0, 1'b0, 1'b0, 1'b0);
      lit("restart y_off full", 3'b000, 1'b1, 1'b0);
`else
      cyc(200, 180, 1'b0, 1'b0, 1'b0, 1'b0);
      lit("restart at origin", FG_RGB, 1'b1, 1'b0);
`endif
      cyc(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);

      for (int i = 0; i < 20000; i++) begin
         int x, y;
         if ($urandom_range(1, 0) == 1) begin
            x = int'($urandom_range(ORG_X + 31 * 8 + 8, ORG_X - 8));
            y = int'($urandom_range(511, ORG_Y - 8));
         end else begin
            x = int'($urandom_range(1023, 0));
            y = int'($urandom_range(511, 0));
         end
         cyc(x, y, 1'($urandom_range(3, 0) == 0), 1'($urandom_range(40, 0) == 0),
             1'($urandom_range(1499, 0) == 0), 1'($urandom_range(4999, 0) == 0));
      end

      @(posedge clk);
      #2;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
